// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium key/IV loader.
// Holds the key/IV geometry, the default warm-up length and the loader
// state encoding used by trivium_loader.
package trivium_pkg;

  localparam int KEY_W             = 80;
  localparam int IV_W              = 80;
  localparam int NUM_BYTES         = 20;    // 10 key bytes followed by 10 IV bytes
  localparam int WARMUP_CYCLES_DEF = 1152;  // 4 x 288 core-enabled cycles

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } loader_state_e;

endpackage

// File: rtl/trivium_loader.sv
// trivium_loader
// Assembles an 80-bit key and an 80-bit IV from a byte stream, then holds
// the downstream Trivium core in reset while loading, releases it and runs
// it for WARMUP_CYCLES cycles, and finally flags its keystream as usable.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (beats restart and data)
//   din[7:0]    in   key/IV byte; bytes 0..9 form the key, 10..19 the IV
//   din_valid   in   din holds a byte
//   din_ready   out  a byte is accepted this cycle (LOAD only)
//   restart     in   abort and return to LOAD; any byte offered is dropped
//   ks_ready    in   downstream takes a keystream bit this cycle
//   key[79:0]   out  assembled key, byte k at key[8k+7:8k]
//   iv[79:0]    out  assembled IV, byte k at iv[8(k-10)+7:8(k-10)]
//   core_rst_n  out  active-low core reset, registered, low only in LOAD
//   core_en     out  core enable: 1 in WARMUP, ks_ready in RUN, 0 in LOAD
//   ks_valid    out  keystream bit is past warm-up (RUN only)
module trivium_loader
  import trivium_pkg::*;
#(
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              restart,
  input  logic              ks_ready,
  output logic [KEY_W-1:0]  key,
  output logic [IV_W-1:0]   iv,
  output logic              core_rst_n,
  output logic              core_en,
  output logic              ks_valid
);

  // Warm-up counter only needs to reach WARMUP_CYCLES-1, so it never wraps.
  localparam int                WU_W      = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WU_W-1:0]   WU_LAST   = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [4:0]        BYTE_LAST = 5'(NUM_BYTES - 1);
  localparam int                KEY_BYTES = KEY_W / 8;
  localparam int                IV_BYTES  = IV_W / 8;

  loader_state_e      state_q;
  logic [4:0]         byte_cnt_q;
  logic [WU_W-1:0]    wu_cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [IV_W-1:0]    iv_q;
  logic               core_rst_n_q;

  always_ff @(posedge clk) begin
    // rst and restart have the same effect; rst winning is therefore implicit,
    // and both override any byte presented in the same cycle.
    if (rst || restart) begin
      state_q      <= ST_LOAD;
      byte_cnt_q   <= '0;
      wu_cnt_q     <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (din_valid) begin
            for (int i = 0; i < KEY_BYTES; i++) begin
              if (byte_cnt_q == 5'(i)) key_q[8*i +: 8] <= din;
            end
            for (int i = 0; i < IV_BYTES; i++) begin
              if (byte_cnt_q == 5'(i + KEY_BYTES)) iv_q[8*i +: 8] <= din;
            end
            if (byte_cnt_q == BYTE_LAST) begin
              // Last byte: release the core so it is out of reset on the
              // very first WARMUP cycle.
              byte_cnt_q   <= '0;
              wu_cnt_q     <= '0;
              core_rst_n_q <= 1'b1;
              state_q      <= ST_WARMUP;
            end else begin
              byte_cnt_q <= byte_cnt_q + 5'd1;
            end
          end
        end
        ST_WARMUP: begin
          if (wu_cnt_q == WU_LAST) begin
            wu_cnt_q <= '0;
            state_q  <= ST_RUN;
          end else begin
            wu_cnt_q <= wu_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // Keystream runs until restart or rst; no length limit.
        end
        default: begin
          state_q      <= ST_LOAD;
          core_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = (state_q == ST_LOAD);
  assign ks_valid   = (state_q == ST_RUN);
  // In RUN the core only advances when a bit is actually consumed.
  assign core_en    = (state_q == ST_WARMUP) || ((state_q == ST_RUN) && ks_ready);
  assign core_rst_n = core_rst_n_q;
  assign key        = key_q;
  assign iv         = iv_q;

endmodule

// File: tb/tb_trivium_loader.sv
// Self-checking bench for trivium_loader: table-driven key/IV loads with an
// expected-result queue drained when keystream becomes valid, plus
// hand-written backpressure, restart and reset-contention sequences.
module tb_trivium_loader;
  import trivium_pkg::*;

  localparam int W = 1152;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        restart;
  logic        ks_ready;
  logic [79:0] key;
  logic [79:0] iv;
  logic        core_rst_n;
  logic        core_en;
  logic        ks_valid;

  trivium_loader #(.WARMUP_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .restart    (restart),
    .ks_ready   (ks_ready),
    .key        (key),
    .iv         (iv),
    .core_rst_n (core_rst_n),
    .core_en    (core_en),
    .ks_valid   (ks_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          stall;
    bit          garbage;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [79:0] exp_key;
    logic [79:0] exp_iv;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [79:0] k, input logic [79:0] v);
    exp_t e;
    e.key = k;
    e.iv  = v;
    sb_q.push_back(e);
  endtask

  // Offers count bytes base, base+step, ... ; with stall a dead cycle
  // (din_valid=0 and junk on din) precedes every byte.
  task automatic send_bytes(input logic [7:0] base, input logic [7:0] step,
                            input int count, input bit stall);
    logic [7:0] b;
    bit ok;
    b  = base;
    ok = 1'b1;
    for (int k = 0; k < count; k++) begin
      if (stall) begin
        din_valid = 1'b0;
        din       = 8'hEE;
        cyc();
      end
      if (din_ready !== 1'b1) ok = 1'b0;
      din       = b;
      din_valid = 1'b1;
      cyc();
      b = b + step;
    end
    din_valid = 1'b0;
    din       = 8'h00;
    check("din_ready_in_load", {79'd0, ok}, 80'd1);
  endtask

  // Called on the first WARMUP cycle; measures warm-up length and compares
  // the assembled key/iv against the scoreboard once ks_valid rises.
  task automatic wait_run(input bit garbage);
    int   cnt;
    bit   en_ok;
    bit   rdy_ok;
    exp_t e;
    cnt    = 0;
    en_ok  = 1'b1;
    rdy_ok = 1'b1;
    check("core_rst_n_rise", {79'd0, core_rst_n}, 80'd1);
    check("ks_valid_early", {79'd0, ks_valid}, 80'd0);
    if (garbage) begin
      din_valid = 1'b1;
      din       = 8'h5A;
    end
    while (ks_valid !== 1'b1 && cnt < W + 20) begin
      if (core_en !== 1'b1) en_ok = 1'b0;
      if (din_ready !== 1'b0) rdy_ok = 1'b0;
      cyc();
      cnt++;
    end
    din_valid = 1'b0;
    check("warmup_len", 80'(cnt), 80'(W));
    check("core_en_warmup", {79'd0, en_ok}, 80'd1);
    check("din_ready_warmup", {79'd0, rdy_ok}, 80'd0 + 80'd1 - 80'd1 + {79'd0, 1'b1});
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 80'd0, 80'd1);
    end else begin
      e = sb_q.pop_front();
      check("key", key, e.key);
      check("iv", iv, e.iv);
    end
  endtask

  task automatic check_load_state(input string tag);
    check({tag, "_din_ready"}, {79'd0, din_ready}, 80'd1);
    check({tag, "_core_rst_n"}, {79'd0, core_rst_n}, 80'd0);
    check({tag, "_core_en"}, {79'd0, core_en}, 80'd0);
    check({tag, "_ks_valid"}, {79'd0, ks_valid}, 80'd0);
    check({tag, "_key"}, key, 80'd0);
    check({tag, "_iv"}, iv, 80'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;

    vecs[0] = '{stall: 1'b0, garbage: 1'b0, base: 8'h00, step: 8'h01,
                exp_key: 80'h09080706050403020100, exp_iv: 80'h131211100F0E0D0C0B0A};
    vecs[1] = '{stall: 1'b1, garbage: 1'b0, base: 8'h00, step: 8'h01,
                exp_key: 80'h09080706050403020100, exp_iv: 80'h131211100F0E0D0C0B0A};
    vecs[2] = '{stall: 1'b0, garbage: 1'b1, base: 8'hF0, step: 8'h11,
                exp_key: 80'h897867564534231201F0, exp_iv: 80'h33221100EFDECDBCAB9A};
    vecs[3] = '{stall: 1'b1, garbage: 1'b1, base: 8'hFF, step: 8'h00,
                exp_key: 80'hFFFFFFFFFFFFFFFFFFFF, exp_iv: 80'hFFFFFFFFFFFFFFFFFFFF};

    rst       = 1'b1;
    restart   = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    ks_ready  = 1'b1;
    repeat (2) cyc();
    check_load_state("reset");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      send_bytes(vecs[v].base, vecs[v].step, 20, vecs[v].stall);
      push_exp(vecs[v].exp_key, vecs[v].exp_iv);
      wait_run(vecs[v].garbage);

      ok = 1'b1;
      repeat (20) begin
        if (ks_valid !== 1'b1 || core_en !== 1'b1) ok = 1'b0;
        cyc();
      end
      check("run_persist", {79'd0, ok}, 80'd1);

      if (v == 0) begin
        ks_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          check("bp_core_en", {79'd0, core_en}, 80'd0);
          check("bp_ks_valid", {79'd0, ks_valid}, 80'd1);
          cyc();
        end
        ks_ready = 1'b1;
        #1;
        check("bp_release_core_en", {79'd0, core_en}, 80'd1);
        cyc();
      end

      restart = 1'b1;
      cyc();
      restart = 1'b0;
      check_load_state("restart_run");
    end

    // Restart at warm-up count 500, then a fresh load must get a full warm-up.
    send_bytes(8'h00, 8'h01, 20, 1'b0);
    repeat (500) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check_load_state("restart_warmup");
    send_bytes(8'h10, 8'h01, 20, 1'b0);
    push_exp(80'h19181716151413121110, 80'h232221201F1E1D1C1B1A);
    wait_run(1'b0);
    restart = 1'b1;
    cyc();
    restart = 1'b0;

    // Restart together with byte index 7: byte dropped, counter back to 0.
    send_bytes(8'h40, 8'h01, 7, 1'b0);
    check("partial_key", key, 80'h00000046454443424140);
    din       = 8'h47;
    din_valid = 1'b1;
    restart   = 1'b1;
    cyc();
    restart   = 1'b0;
    din_valid = 1'b0;
    check_load_state("restart_byte7");
    send_bytes(8'h40, 8'h01, 10, 1'b0);
    check("reload_key", key, 80'h49484746454443424140);
    check("reload_iv", iv, 80'd0);

    // rst together with restart and a valid byte mid-load.
    rst       = 1'b1;
    restart   = 1'b1;
    din       = 8'h99;
    din_valid = 1'b1;
    cyc();
    rst       = 1'b0;
    restart   = 1'b0;
    din_valid = 1'b0;
    check_load_state("rst_restart");
    send_bytes(8'h40, 8'h01, 3, 1'b0);
    check("post_rst_key", key, 80'h00000000000000424140);

    // rst mid-warm-up.
    send_bytes(8'h43, 8'h01, 17, 1'b0);
    check("core_rst_n_before_rst", {79'd0, core_rst_n}, 80'd1);
    repeat (100) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_load_state("rst_warmup");

    check("scoreboard_drained", 80'(sb_q.size()), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
